// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory block.
package imem_pkg;

    localparam int          IMEM_ADDR_W = 32;
    localparam logic [31:0] IMEM_NOP    = 32'h0000_0000;

    // One queued fetch response: instruction word plus error flag.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } imem_rsp_t;

    // Width of the word index for a memory of the given depth.
    function automatic int imem_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response FIFO: RSP_DEPTH entries of imem_rsp_t. Pointers wrap modulo
// RSP_DEPTH (any depth, not only powers of two) and the occupancy is kept
// in its own register, so full and empty never need pointer comparison.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int RSP_DEPTH = 2,
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1,
    localparam int CW = $clog2(RSP_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  imem_rsp_t     wdata_i,
    input  logic          pop_i,
    output imem_rsp_t     rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    imem_rsp_t     store_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(RSP_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = store_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset needed since entries are only read when valid.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) store_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/imem_sync_rd.sv
// Synchronous-read instruction memory with valid/ready request and response
// channels. The word is looked up in the acceptance cycle and lands in the
// response FIFO on the following edge. A credit counter bounds outstanding
// requests to the FIFO depth so a stalled consumer never loses a word.
// Optional load port enabled by defining IMEM_LOAD_EN.
module imem_sync_rd
    import imem_pkg::*;
#(
    parameter int    DEPTH     = 128,
    parameter int    RSP_DEPTH = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [IMEM_ADDR_W-1:0] ReqAddr,
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic [31:0]            RspData,
    output logic                   RspErr
`ifdef IMEM_LOAD_EN
    ,
    input  logic                   LoadEn,
    input  logic [IMEM_ADDR_W-1:0] LoadAddr,
    input  logic [31:0]            LoadData
`endif
);

    localparam int          IW         = imem_idx_w(DEPTH);
    localparam int          CRW        = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef logic [31:0] word_arr_t [DEPTH];

    // Power-up image: each word holds its byte address.
    function automatic word_arr_t init_image();
        word_arr_t img;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'(i * 4);
        return img;
    endfunction

    word_arr_t mem_q = init_image();

    logic [CRW-1:0] credits_q, credits_d;
    imem_rsp_t      rd_rsp, head_rsp, last_q;
    logic [CRW-1:0] fifo_count;
    logic           fifo_full, fifo_empty;
    logic           accept, pop, in_range;
    logic [IW-1:0]  rd_idx;

    assign ReqReady = (credits_q != '0);
    assign accept   = ReqValid && ReqReady;
    assign RspValid = !fifo_empty;
    assign pop      = RspValid && RspReady;

    assign rd_idx   = ReqAddr[IW+1:2];
    assign in_range = (ReqAddr < ADDR_LIMIT);

    // Lookup and error classification; out-of-range returns a NOP.
    always_comb begin
        rd_rsp.data = in_range ? mem_q[rd_idx] : IMEM_NOP;
        rd_rsp.err  = !in_range || (ReqAddr[1:0] != 2'b00);
    end

    // Credits: one consumed per accept, one returned per pop.
    always_comb begin
        credits_d = credits_q;
        case ({accept, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Credit and last-presented-response registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            credits_q <= CRW'(RSP_DEPTH);
            last_q    <= '0;
        end else begin
            credits_q <= credits_d;
            if (RspValid) last_q <= head_rsp;
        end
    end

    imem_rsp_fifo #(.RSP_DEPTH(RSP_DEPTH)) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (accept),
        .wdata_i (rd_rsp),
        .pop_i   (pop),
        .rdata_o (head_rsp),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Present the FIFO head; hold the last presented word while empty.
    always_comb begin
        RspData = RspValid ? head_rsp.data : last_q.data;
        RspErr  = RspValid ? head_rsp.err  : last_q.err;
    end

    // Credits and FIFO occupancy always sum to the FIFO depth.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (int'(credits_q) + int'(fifo_count) == RSP_DEPTH);
            assert (!(fifo_full && ReqReady));
        end
    end

`ifdef IMEM_LOAD_EN
    // Load port: writes take effect at the edge, so same-cycle reads see old data.
    always_ff @(posedge Clk) begin
        if (LoadEn && (LoadAddr < ADDR_LIMIT)) mem_q[LoadAddr[IW+1:2]] <= LoadData;
    end
`endif

endmodule

// File: tb/tb_imem_sync_rd.sv
// Self-checking bench for imem_sync_rd (DEPTH=128, RSP_DEPTH=2).
module tb_imem_sync_rd;

    localparam int DEPTH     = 128;
    localparam int RSP_DEPTH = 2;

    logic        Clk = 1'b0;
    logic        Reset, ReqValid, ReqReady, RspValid, RspReady, RspErr;
    logic [31:0] ReqAddr, RspData;
`ifdef IMEM_LOAD_EN
    logic        LoadEn;
    logic [31:0] LoadAddr, LoadData;
`endif

    always #5 Clk = ~Clk;

    imem_sync_rd #(.DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqAddr  (ReqAddr),
        .RspValid (RspValid),
        .RspReady (RspReady),
        .RspData  (RspData),
        .RspErr   (RspErr)
`ifdef IMEM_LOAD_EN
        ,
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    rsp_t        exp_q[$];
    rsp_t        last_exp;
    logic [31:0] exp_mem [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference read: plain arithmetic on the byte address.
    function automatic rsp_t model_rd(input logic [31:0] a);
        rsp_t r;
        if (a >= 32'(DEPTH * 4)) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end else begin
            r.data = exp_mem[int'(a >> 2)];
            r.err  = (a[1:0] != 2'b00);
        end
        return r;
    endfunction

    task automatic check_outs();
        chk("ReqReady", 32'(ReqReady), 32'(exp_q.size() < RSP_DEPTH));
        chk("RspValid", 32'(RspValid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) last_exp = exp_q[0];
        chk("RspData", RspData, last_exp.data);
        chk("RspErr", 32'(RspErr), 32'(last_exp.err));
    endtask

    // One clock: decide handshakes from the model, advance, then compare.
    task automatic tick();
        bit   acc, pop;
        rsp_t r;
        acc = ReqValid && (exp_q.size() < RSP_DEPTH) && !Reset;
        pop = RspReady && (exp_q.size() > 0) && !Reset;
        r   = model_rd(ReqAddr);
        @(posedge Clk);
`ifdef IMEM_LOAD_EN
        if (LoadEn && LoadAddr < 32'(DEPTH * 4)) exp_mem[int'(LoadAddr >> 2)] = LoadData;
`endif
        if (Reset) begin
            exp_q.delete();
            last_exp = '{32'h0, 1'b0};
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(r);
        end
        @(negedge Clk);
        check_outs();
    endtask

    vec_t        vt [9];
    logic [31:0] t2_addr [4];

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; RspReady = 1'b0; ReqAddr = '0;
`ifdef IMEM_LOAD_EN
        LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
`endif
        last_exp = '{32'h0, 1'b0};
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'(i * 4);

        vt[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[1] = '{32'h0000_0004, 32'h0000_0004, 1'b0};
        vt[2] = '{32'h0000_0080, 32'h0000_0080, 1'b0};
        vt[3] = '{32'h0000_01FC, 32'h0000_01FC, 1'b0};
        vt[4] = '{32'h0000_0200, 32'h0000_0000, 1'b1};
        vt[5] = '{32'h0000_0006, 32'h0000_0004, 1'b1};
        vt[6] = '{32'h0000_01FF, 32'h0000_01FC, 1'b1};
        vt[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vt[8] = '{32'h0000_0203, 32'h0000_0000, 1'b1};

        // Reset for two cycles.
        @(negedge Clk);
        tick(); tick();
        Reset = 1'b0;
        chk("rst_RspValid", 32'(RspValid), 32'h0);
        chk("rst_RspData", RspData, 32'h0);
        chk("rst_RspErr", 32'(RspErr), 32'h0);
        chk("rst_ReqReady", 32'(ReqReady), 32'h1);

        // Back-to-back fetches, response one cycle after each accept.
        RspReady = 1'b1; ReqValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ReqAddr = 32'(i * 4);
            tick();
            chk("t1_vld", 32'(RspValid), 32'h1);
            chk("t1_data", RspData, 32'(i * 4));
            chk("t1_err", 32'(RspErr), 32'h0);
        end
        ReqValid = 1'b0;
        tick();

        // Single-request vector table, including range and alignment edges.
        for (int i = 0; i < 9; i++) begin
            RspReady = 1'b0; ReqValid = 1'b1; ReqAddr = vt[i].addr;
            tick();
            ReqValid = 1'b0;
            chk("vec_vld", 32'(RspValid), 32'h1);
            chk("vec_data", RspData, vt[i].data);
            chk("vec_err", 32'(RspErr), 32'(vt[i].err));
            RspReady = 1'b1;
            tick();
        end

        // Backpressure: four requests against a two-entry FIFO.
        t2_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
        begin
            int idx = 0;
            RspReady = 1'b0; ReqValid = 1'b1;
            for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
                bit acc;
                ReqAddr = t2_addr[idx];
                if (cyc == 4) chk("t2_stall", 32'(ReqReady), 32'h0);
                if (cyc == 5) RspReady = 1'b1;
                acc = exp_q.size() < RSP_DEPTH;
                tick();
                if (acc) idx++;
            end
            chk("t2_all_accepted", 32'(idx), 32'd4);
            ReqValid = 1'b0; RspReady = 1'b1;
            repeat (3) tick();
        end

        // Reset with two responses queued drops them.
        RspReady = 1'b0; ReqValid = 1'b1;
        ReqAddr = 32'h20; tick();
        ReqAddr = 32'h24; tick();
        ReqValid = 1'b0;
        chk("t4_queued", 32'(RspValid), 32'h1);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("t4_vld", 32'(RspValid), 32'h0);
        chk("t4_rdy", 32'(ReqReady), 32'h1);
        RspReady = 1'b1;
        repeat (5) tick();

        // One entry queued, then accept and pop every cycle.
        RspReady = 1'b0; ReqValid = 1'b1; ReqAddr = 32'h40;
        tick();
        RspReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ReqAddr = 32'h40 + 32'(4 * (i + 1));
            tick();
            chk("t5_rdy", 32'(ReqReady), 32'h1);
            chk("t5_vld", 32'(RspValid), 32'h1);
            chk("t5_data", RspData, 32'h40 + 32'(4 * (i + 1)));
        end
        ReqValid = 1'b0;
        repeat (2) tick();

`ifdef IMEM_LOAD_EN
        // Read-before-write on the load port.
        RspReady = 1'b1; ReqValid = 1'b1; ReqAddr = 32'h10;
        LoadEn = 1'b1; LoadAddr = 32'h10; LoadData = 32'h2008_0005;
        tick();
        LoadEn = 1'b0; ReqValid = 1'b0;
        chk("t6_old", RspData, 32'h10);
        ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
        chk("t6_new", RspData, 32'h2008_0005);
        tick();
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            int sel;
            ReqValid = ($urandom_range(0, 3) != 0);
            RspReady = ($urandom_range(0, 3) != 0);
            Reset    = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      ReqAddr = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel < 8) ReqAddr = 32'($urandom_range(0, DEPTH * 4 - 1));
            else              ReqAddr = 32'(DEPTH * 4) + $urandom_range(0, 1000);
            tick();
        end
        Reset = 1'b0; ReqValid = 1'b0; RspReady = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
